// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial 1011 pattern detector.
// The state codes double as the debug encoding on state_o.
package seq_det_pkg;

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        FOUND = 3'd4
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1011;
    localparam int         PAT_LEN = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/seq_detector_1011.sv
// Moore detector for the serial pattern 1011 (first bit first) on the
// latched data bit, with a saturating match counter.
module seq_detector_1011
    import seq_det_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter bit OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [2:0]       state_o
);

    state_t state_q;
    state_t state_d;
    logic   inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Illegal codes recover to S0 even while sampling is disabled.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0: begin
                if (en) state_d = (din == PATTERN[PAT_LEN-1]) ? S1 : S0;
            end
            S1: begin
                if (en) state_d = (din == PATTERN[PAT_LEN-2]) ? S10 : S1;
            end
            S10: begin
                if (en) state_d = (din == PATTERN[PAT_LEN-3]) ? S101 : S0;
            end
            S101: begin
                if (en) state_d = (din == PATTERN[PAT_LEN-4]) ? FOUND : S10;
            end
            FOUND: begin
                if (en) begin
                    if (din) state_d = S1;
                    else     state_d = OVERLAP ? S10 : S0;
                end
            end
            default: state_d = S0;
        endcase
    end

    always_comb begin
        match   = (state_q == FOUND);
        state_o = state_q;
    end

    assign inc = en && (state_d == FOUND);

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (inc),
        .clr_i  (clr),
        .count_o(match_count)
    );

endmodule

// File: tb/tb_seq_detector_1011.sv
// Bench for seq_detector_1011: three configurations share one stimulus stream,
// a spec-level model pushes expected results that are popped after each edge.
module tb_seq_detector_1011;

    logic clk;
    logic reset;
    logic en;
    logic din;
    logic clr;

    logic       m_a, m_b, m_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic [2:0] st_a, st_b, st_c;

    seq_detector_1011 #(.CNT_W(8), .OVERLAP(1'b1)) dut_a (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr),
        .match(m_a), .match_count(cnt_a), .state_o(st_a)
    );

    seq_detector_1011 #(.CNT_W(8), .OVERLAP(1'b0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr),
        .match(m_b), .match_count(cnt_b), .state_o(st_b)
    );

    seq_detector_1011 #(.CNT_W(2), .OVERLAP(1'b1)) dut_c (
        .clk(clk), .reset(reset), .en(en), .din(din), .clr(clr),
        .match(m_c), .match_count(cnt_c), .state_o(st_c)
    );

    typedef struct {
        logic [2:0] sa, sb, sc;
        logic [7:0] ca, cb;
        logic [1:0] cc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    logic [2:0] ms_a, ms_b, ms_c;
    logic [7:0] mc_a, mc_b;
    logic [1:0] mc_c;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time expired, required completion");
        $fatal(1);
    end

    function automatic logic [2:0] nxt(logic [2:0] s, bit ev, bit d, bit ov);
        if (s > 3'd4) return 3'd0;
        if (!ev) return s;
        case (s)
            3'd0:    return d ? 3'd1 : 3'd0;
            3'd1:    return d ? 3'd1 : 3'd2;
            3'd2:    return d ? 3'd3 : 3'd0;
            3'd3:    return d ? 3'd4 : 3'd2;
            default: return d ? 3'd1 : (ov ? 3'd2 : 3'd0);
        endcase
    endfunction

    task automatic model_reset();
        ms_a = 0; ms_b = 0; ms_c = 0;
        mc_a = 0; mc_b = 0; mc_c = 0;
        sb_q.delete();
    endtask

    task automatic cycle(input bit ev, input bit d, input bit c);
        exp_t x;
        @(negedge clk);
        en = ev; din = d; clr = c;
        ms_a = nxt(ms_a, ev, d, 1'b1);
        ms_b = nxt(ms_b, ev, d, 1'b0);
        ms_c = nxt(ms_c, ev, d, 1'b1);
        if (c) mc_a = 0;
        else if (ev && ms_a == 3'd4 && mc_a != 8'hff) mc_a = mc_a + 1;
        if (c) mc_b = 0;
        else if (ev && ms_b == 3'd4 && mc_b != 8'hff) mc_b = mc_b + 1;
        if (c) mc_c = 0;
        else if (ev && ms_c == 3'd4 && mc_c != 2'b11) mc_c = mc_c + 1;
        x.sa = ms_a; x.sb = ms_b; x.sc = ms_c;
        x.ca = mc_a; x.cb = mc_b; x.cc = mc_c;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (st_a !== 3'd0 || m_a !== 1'b0 || cnt_a !== 8'd0 ||
            st_b !== 3'd0 || cnt_b !== 8'd0 || st_c !== 3'd0 || cnt_c !== 2'd0) begin
            errors++;
            $display("FAIL reset: state=%0d match=%0b count=%0d required 0/0/0",
                     st_a, m_a, cnt_a);
        end
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b1011;
        logic [3:0] exp_m = 4'b0001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, bits[3-i], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (st_a !== e.sa || m_a !== exp_m[3-i] || cnt_a !== e.ca) begin
                errors++;
                $display("FAIL basic[%0d]: state=%0d match=%0b count=%0d required %0d/%0b/%0d",
                         i, st_a, m_a, cnt_a, e.sa, exp_m[3-i], e.ca);
            end
        end
        checks++;
        if (st_a !== 3'd4 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL basic_end: state=%0d count=%0d required 4/1", st_a, cnt_a);
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] bits = 6'b101101;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, bits[5-i], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (st_a !== e.sa || cnt_a !== e.ca) begin
                errors++;
                $display("FAIL areset_pre[%0d]: state=%0d count=%0d required %0d/%0d",
                         i, st_a, cnt_a, e.sa, e.ca);
            end
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (st_a !== 3'd0 || m_a !== 1'b0 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL areset_now: state=%0d match=%0b count=%0d required 0/0/0",
                     st_a, m_a, cnt_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (st_a !== 3'd0 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL areset_hold: state=%0d count=%0d required 0/0", st_a, cnt_a);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 1'b1, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (st_a !== 3'd1 || st_a !== e.sa) begin
            errors++;
            $display("FAIL areset_restart: state=%0d required 1", st_a);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits  = 7'b1011011;
        logic [6:0] exp_a = 7'b0001001;
        logic [6:0] exp_b = 7'b0001000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, bits[6-i], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (st_a !== e.sa || m_a !== exp_a[6-i] || cnt_a !== e.ca ||
                st_b !== e.sb || m_b !== exp_b[6-i] || cnt_b !== e.cb) begin
                errors++;
                $display("FAIL overlap[%0d]: ov1 %0d/%0b/%0d ov0 %0d/%0b/%0d required ov1 %0d/%0b/%0d ov0 %0d/%0b/%0d",
                         i, st_a, m_a, cnt_a, st_b, m_b, cnt_b,
                         e.sa, exp_a[6-i], e.ca, e.sb, exp_b[6-i], e.cb);
            end
        end
        checks++;
        if (cnt_a !== 8'd2 || cnt_b !== 8'd1) begin
            errors++;
            $display("FAIL overlap_cnt: ov1=%0d ov0=%0d required 2/1", cnt_a, cnt_b);
        end
    endtask

    task automatic test_enable();
        logic [2:0] pre = 3'b101;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, pre[2-i], 1'b0);
            void'(sb_q.pop_front());
        end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, i[0], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (st_a !== 3'd3 || m_a !== 1'b0 || st_a !== e.sa) begin
                errors++;
                $display("FAIL enable_hold[%0d]: state=%0d match=%0b required 3/0",
                         i, st_a, m_a);
            end
        end
        cycle(1'b1, 1'b1, 1'b0);
        e = sb_q.pop_front();
        checks++;
        if (m_a !== 1'b1 || cnt_a !== 8'd1 || cnt_a !== e.ca) begin
            errors++;
            $display("FAIL enable_match: match=%0b count=%0d required 1/1", m_a, cnt_a);
        end
        cycle(1'b0, 1'b0, 1'b0);
        void'(sb_q.pop_front());
        checks++;
        if (m_a !== 1'b1 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL enable_found_hold: match=%0b count=%0d required 1/1", m_a, cnt_a);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] bits = 16'b1011011011011011;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, bits[15-i], 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (st_c !== e.sc || m_c !== (e.sc == 3'd4) || cnt_c !== e.cc) begin
                errors++;
                $display("FAIL sat[%0d]: state=%0d match=%0b count=%0d required %0d/%0b/%0d",
                         i, st_c, m_c, cnt_c, e.sc, e.sc == 3'd4, e.cc);
            end
        end
        checks++;
        if (cnt_c !== 2'd3 || cnt_a !== 8'd5) begin
            errors++;
            $display("FAIL sat_cap: cnt2=%0d cnt8=%0d required 3/5", cnt_c, cnt_a);
        end
        cycle(1'b1, 1'b0, 1'b0);
        void'(sb_q.pop_front());
        cycle(1'b1, 1'b1, 1'b0);
        void'(sb_q.pop_front());
        cycle(1'b1, 1'b1, 1'b1);
        e = sb_q.pop_front();
        checks++;
        if (m_c !== 1'b1 || cnt_c !== 2'd0 || st_a !== 3'd4 || cnt_a !== e.ca) begin
            errors++;
            $display("FAIL clr_priority: match=%0b count=%0d state8=%0d required 1/0/4",
                     m_c, cnt_c, st_a);
        end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            force dut_a.state_q = seq_det_pkg::state_t'(3'd6);
            #1;
            release dut_a.state_q;
            ms_a = 3'd6;
            cycle(k[0], 1'b1, 1'b0);
            e = sb_q.pop_front();
            checks++;
            if (st_a !== 3'd0 || st_a !== e.sa || m_a !== 1'b0) begin
                errors++;
                $display("FAIL illegal_en%0d: state=%0d match=%0b required 0/0",
                         k, st_a, m_a);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        din   = 1'b0;
        clr   = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_async_reset();
        test_overlap();
        test_enable();
        test_saturation();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
